// File: rtl/ibuffer_pkg.sv
// Shared frontend types for the instruction buffer: default depth and the {inst, pc} entry.
// Also provides a default for the PC_RANGE macro when the build does not supply one.
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif

package ibuffer_pkg;
    localparam int IBUF_DEPTH = 8;

    typedef struct packed {
        logic [31:0]       inst;
        logic [`PC_RANGE]  pc;
    } ibuf_entry_t;
endpackage

// File: rtl/ibuffer.sv
// Instruction buffer between fetch and decode: circular FIFO of {inst, pc}, 1-2 pushes / 1 pop per cycle.
// Optional perf counters (empty cycles, full stalls) are built when IBUFFER_PERF_CNT_EN is defined.
module ibuffer
    import ibuffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [63:0]      fetch_block,
    input  logic [`PC_RANGE] fetch_pc,
    input  logic             redirect_valid,
    output logic             ibuffer_instr_valid,
    input  logic             ibuffer_ready,
    output logic [31:0]      ibuffer_inst_out,
    output logic [`PC_RANGE] ibuffer_pc_out
`ifdef IBUFFER_PERF_CNT_EN
    ,
    output logic [31:0]      perf_empty_cycles,
    output logic [31:0]      perf_full_stalls
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        DEPTH_P = DEPTH[AW:0];
    localparam logic [AW:0]        ONE     = 1;
    localparam logic [AW:0]        TWO     = 2;
    localparam logic [`PC_RANGE]   PC_STEP = 4;

    ibuf_entry_t mem_q [DEPTH];
    ibuf_entry_t e0, e1, head;

    logic [AW:0]   rptr_q, rptr_d, wptr_q, wptr_d, count, free;
    logic [AW-1:0] widx0, widx1;
    logic          empty, push, pop, two;

    assign count = wptr_q - rptr_q;
    assign free  = DEPTH_P - count;
    assign empty = (rptr_q == wptr_q);

    assign fetch_ready         = reset_n && (free >= TWO) && !redirect_valid;
    assign ibuffer_instr_valid = reset_n && !empty && !redirect_valid;

    assign push = fetch_valid && fetch_ready;
    assign pop  = ibuffer_instr_valid && ibuffer_ready;
    // An aligned block carries two wanted instructions; a base+4 PC wants only the upper one.
    assign two  = !fetch_pc[2];

    assign e0.inst = two ? fetch_block[31:0] : fetch_block[63:32];
    assign e0.pc   = fetch_pc;
    assign e1.inst = fetch_block[63:32];
    assign e1.pc   = fetch_pc + PC_STEP;

    assign widx0 = wptr_q[AW-1:0];
    assign widx1 = widx0 + 1'b1;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (redirect_valid) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + (two ? TWO : ONE);
            if (pop)  rptr_d = rptr_q + ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[widx0] <= e0;
            if (two) mem_q[widx1] <= e1;
        end
    end

    assign head             = mem_q[rptr_q[AW-1:0]];
    assign ibuffer_inst_out = reset_n ? head.inst : '0;
    assign ibuffer_pc_out   = reset_n ? head.pc   : '0;

`ifdef IBUFFER_PERF_CNT_EN
    logic [31:0] perf_empty_q, perf_empty_d, perf_stall_q, perf_stall_d;

    // Saturating; deliberately survive redirects so they measure whole-run behaviour.
    always_comb begin
        perf_empty_d = perf_empty_q;
        perf_stall_d = perf_stall_q;
        if (empty && (perf_empty_q != '1))
            perf_empty_d = perf_empty_q + 32'd1;
        if (fetch_valid && !fetch_ready && !redirect_valid && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_empty_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_empty_q <= perf_empty_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_empty_cycles = perf_empty_q;
    assign perf_full_stalls  = perf_stall_q;
`endif
endmodule

// File: tb/tb_ibuffer.sv
// Self-checking bench for ibuffer: directed vector table, full/redirect sequences, random traffic vs a queue model.
module tb_ibuffer;
    import ibuffer_pkg::*;

    localparam int DEPTH = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             fetch_valid = 1'b0;
    logic             fetch_ready;
    logic [63:0]      fetch_block = '0;
    logic [`PC_RANGE] fetch_pc = '0;
    logic             redirect_valid = 1'b0;
    logic             ibuffer_instr_valid;
    logic             ibuffer_ready = 1'b0;
    logic [31:0]      ibuffer_inst_out;
    logic [`PC_RANGE] ibuffer_pc_out;
`ifdef IBUFFER_PERF_CNT_EN
    logic [31:0]      perf_empty_cycles, perf_full_stalls;
`endif

    ibuffer #(.DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_block         (fetch_block),
        .fetch_pc            (fetch_pc),
        .redirect_valid      (redirect_valid),
        .ibuffer_instr_valid (ibuffer_instr_valid),
        .ibuffer_ready       (ibuffer_ready),
        .ibuffer_inst_out    (ibuffer_inst_out),
        .ibuffer_pc_out      (ibuffer_pc_out)
`ifdef IBUFFER_PERF_CNT_EN
        ,
        .perf_empty_cycles   (perf_empty_cycles),
        .perf_full_stalls    (perf_full_stalls)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    ibuf_entry_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare handshake flags against the model count, pop on consume, push on accept.
    always @(negedge clock) begin
        if (reset_n) begin
            ibuf_entry_t e;
            chk("sb_fetch_ready", fetch_ready,
                ((DEPTH - sb.size()) >= 2) && !redirect_valid);
            chk("sb_instr_valid", ibuffer_instr_valid, (sb.size() != 0) && !redirect_valid);
            if (ibuffer_instr_valid && ibuffer_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_inst", ibuffer_inst_out, e.inst);
                    chk("sb_pc", ibuffer_pc_out, e.pc);
                end
            end
            if (redirect_valid) begin
                sb.delete();
            end else if (fetch_valid && fetch_ready) begin
                if (fetch_pc[2] == 1'b0) begin
                    e.inst = fetch_block[31:0];  e.pc = fetch_pc;      sb.push_back(e);
                    e.inst = fetch_block[63:32]; e.pc = fetch_pc + 4;  sb.push_back(e);
                end else begin
                    e.inst = fetch_block[63:32]; e.pc = fetch_pc;      sb.push_back(e);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [63:0] blk;
        int          n;
        logic [31:0] i0, p0, i1, p1;
    } vec_t;

    vec_t vt[4];

    task automatic drain(input string nm);
        ibuffer_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        step();
        chk({nm, "_drained"}, sb.size(), 0);
        @(negedge clock);
        chk({nm, "_empty_valid"}, ibuffer_instr_valid, 1'b0);
        ibuffer_ready = 1'b0;
    endtask

    initial begin
        vt[0] = '{32'h8000_0000, 64'h00A0_0093_0010_0513, 2,
                  32'h0010_0513, 32'h8000_0000, 32'h00A0_0093, 32'h8000_0004};
        vt[1] = '{32'h8000_0004, 64'h00A0_0093_0010_0513, 1,
                  32'h00A0_0093, 32'h8000_0004, 32'h0, 32'h0};
        vt[2] = '{32'hFFFF_FFF8, 64'h1111_1111_2222_2222, 2,
                  32'h2222_2222, 32'hFFFF_FFF8, 32'h1111_1111, 32'hFFFF_FFFC};
        vt[3] = '{32'h0000_1004, 64'hDEAD_BEEF_CAFE_F00D, 1,
                  32'hDEAD_BEEF, 32'h0000_1004, 32'h0, 32'h0};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_instr_valid", ibuffer_instr_valid, 1'b0);
        chk("rst_fetch_ready", fetch_ready, 1'b0);
        chk("rst_inst_out", ibuffer_inst_out, 32'h0);
        chk("rst_pc_out", ibuffer_pc_out, 32'h0);
`ifdef IBUFFER_PERF_CNT_EN
        chk("rst_perf_empty", perf_empty_cycles, 32'h0);
        chk("rst_perf_stall", perf_full_stalls, 32'h0);
`endif
        step();
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_fetch_ready", fetch_ready, 1'b1);

        // Directed vectors: one packet into an empty buffer, then consumed back to back.
        for (int k = 0; k < 4; k++) begin
            step();
            fetch_valid = 1'b1;
            fetch_pc    = vt[k].pc;
            fetch_block = vt[k].blk;
            step();
            fetch_valid   = 1'b0;
            ibuffer_ready = 1'b1;
            @(negedge clock);
            chk($sformatf("v%0d_valid0", k), ibuffer_instr_valid, 1'b1);
            chk($sformatf("v%0d_inst0", k), ibuffer_inst_out, vt[k].i0);
            chk($sformatf("v%0d_pc0", k), ibuffer_pc_out, vt[k].p0);
            step();
            @(negedge clock);
            if (vt[k].n == 2) begin
                chk($sformatf("v%0d_valid1", k), ibuffer_instr_valid, 1'b1);
                chk($sformatf("v%0d_inst1", k), ibuffer_inst_out, vt[k].i1);
                chk($sformatf("v%0d_pc1", k), ibuffer_pc_out, vt[k].p1);
                step();
                @(negedge clock);
            end
            chk($sformatf("v%0d_done_empty", k), ibuffer_instr_valid, 1'b0);
            ibuffer_ready = 1'b0;
        end

        // Fill with four aligned packets while the backend stalls.
        for (int k = 0; k < 4; k++) begin
            step();
            fetch_valid = 1'b1;
            fetch_pc    = 32'h0000_0100 + 32'(8 * k);
            fetch_block = {32'hA000_0000 + 32'(2 * k + 1), 32'hA000_0000 + 32'(2 * k)};
            if (k == 3) begin
                @(negedge clock);
                chk("full_ready_after3", fetch_ready, 1'b1);
            end
        end
        step();
        fetch_pc = 32'h0000_0200;
        @(negedge clock);
        chk("full_ready_after4", fetch_ready, 1'b0);
`ifdef IBUFFER_PERF_CNT_EN
        begin
            logic [31:0] s0;
            s0 = perf_full_stalls;
            repeat (3) step();
            @(negedge clock);
            chk("perf_full_stalls_inc", perf_full_stalls, s0 + 32'd3);
        end
`else
        repeat (3) step();
`endif
        @(negedge clock);
        chk("full_hold_ready", fetch_ready, 1'b0);
        step();
        fetch_valid = 1'b0;
        drain("full");

        // Redirect with five entries buffered and a packet offered in the same cycle.
        for (int k = 0; k < 3; k++) begin
            step();
            fetch_valid = 1'b1;
            fetch_pc    = (k == 1) ? 32'h0000_2004 : 32'h0000_2000 + 32'(16 * k);
            fetch_block = {32'hB000_0000 + 32'(2 * k + 1), 32'hB000_0000 + 32'(2 * k)};
        end
        step();
        fetch_valid    = 1'b1;
        redirect_valid = 1'b1;
        fetch_pc       = 32'h0000_3000;
        fetch_block    = 64'hEEEE_EEEE_DDDD_DDDD;
        @(negedge clock);
        chk("redir_ready_low", fetch_ready, 1'b0);
        chk("redir_valid_low", ibuffer_instr_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        fetch_valid    = 1'b0;
        @(negedge clock);
        chk("post_redir_valid", ibuffer_instr_valid, 1'b0);
        chk("post_redir_ready", fetch_ready, 1'b1);
        step();
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0000_4000;
        fetch_block = 64'h0000_0002_0000_0001;
        step();
        fetch_valid = 1'b0;
        @(negedge clock);
        chk("post_redir_head_inst", ibuffer_inst_out, 32'h0000_0001);
        chk("post_redir_head_pc", ibuffer_pc_out, 32'h0000_4000);
        drain("redir");

        // Random traffic across many pointer wraps.
        for (int c = 0; c < 300; c++) begin
            step();
            fetch_valid    = $urandom_range(0, 1) == 1;
            fetch_pc       = $urandom() & 32'hFFFF_FFFC;
            fetch_block    = {$urandom(), $urandom()};
            ibuffer_ready  = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 30) == 0;
        end
        step();
        fetch_valid    = 1'b0;
        redirect_valid = 1'b0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
